// File: rtl/riscv_pkg.sv
// Types and constants shared by the pipeline control blocks.
package riscv_pkg;

    localparam int DMEM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_stage_ctrl_wait_timer.sv
// Wait counter for a data-memory access. It counts enabled cycles and flags
// the cycle in which the count would reach MAX_WAIT.
module wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the MAX_WAIT-th enabled cycle, so the caller can leave on that edge.
    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory handshake, pipeline freeze and bubble
// injection, front-end flush for taken branches, and access timeout.
//
// state  | meaning
// IDLE   | no access in flight; a load/store on EX/MEM starts one
// ACCESS | request outstanding, waiting for ack or timeout
// DONE   | access finished; completed instruction advances to MEM/WB
// ERROR  | timeout; pipeline frozen until reset
module mem_stage_ctrl
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [DMEM_WIDTH-1:0] in_alu_out,
    input  logic [DMEM_WIDTH-1:0] in_mem_data,
    input  logic                  in_branch_inst,
    input  logic                  in_branch_taken,
    input  logic                  in_dmem_ack,
    input  logic [DMEM_WIDTH-1:0] in_dmem_rdata,
    output logic                  out_dmem_req,
    output logic                  out_dmem_we,
    output logic [DMEM_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WIDTH-1:0] out_dmem_wdata,
    output logic                  out_stall,
    output logic                  out_memwb_bubble,
    output logic                  out_flush,
    output logic [DMEM_WIDTH-1:0] out_load_data,
    output logic                  out_bus_error
);

    mem_ctrl_state_t       state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DMEM_WIDTH-1:0] addr_q, addr_d;
    logic [DMEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [DMEM_WIDTH-1:0] load_data_q, load_data_d;
    logic                  bus_error_q, bus_error_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;
    logic mem_op;

    assign mem_op = in_mem_read | in_mem_write;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        bus_error_d = bus_error_q;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req_d   = 1'b1;
                    we_d    = in_mem_write;   // read+write together is a store
                    addr_d  = in_alu_out;
                    wdata_d = in_mem_data;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                tmr_en  = 1'b1;
                tmr_clr = in_dmem_ack;
                if (in_dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        load_data_d = in_dmem_rdata;
                    end
                    state_d = DONE;
                end else if (tmr_expired) begin
                    req_d       = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = ERROR;
                end
            end
            // The op is still on EX/MEM here but has already been serviced.
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Freeze depends only on state and the EX/MEM flags, never on the ack.
    assign out_stall        = ((state_q == IDLE) && mem_op) ||
                              (state_q == ACCESS) || (state_q == ERROR);
    assign out_memwb_bubble = out_stall;
    assign out_flush        = in_branch_inst && in_branch_taken && (state_q == IDLE);

    assign out_dmem_req   = req_q;
    assign out_dmem_we    = we_q;
    assign out_dmem_addr  = addr_q;
    assign out_dmem_wdata = wdata_q;
    assign out_load_data  = load_data_q;
    assign out_bus_error  = bus_error_q;

endmodule
